// File: rtl/tick_sched_if.sv
// rtl/tick_sched_if.sv - arm command and expiry event handshake bundle for tick_sched
interface tick_sched_if #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 16
);
  logic             i_arm;
  logic [CH_W-1:0]  i_arm_ch;
  logic [CNT_W-1:0] i_arm_cnt;
  logic             i_arm_per;
  logic             o_exp_valid;
  logic [CH_W-1:0]  o_exp_ch;
  logic             i_exp_ready;

  modport master (
    output i_arm, i_arm_ch, i_arm_cnt, i_arm_per, i_exp_ready,
    input  o_exp_valid, o_exp_ch
  );

  modport slave (
    input  i_arm, i_arm_ch, i_arm_cnt, i_arm_per, i_exp_ready,
    output o_exp_valid, o_exp_ch
  );
endinterface

// File: rtl/tick_sched.sv
// rtl/tick_sched.sv - multi-channel tick countdown scheduler with round-robin expiry reporting
module tick_sched #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stb,
  tick_sched_if.slave     bus,
  output logic [N_CH-1:0] o_active,
  output logic [N_CH-1:0] o_ovr
);

  logic [CNT_W-1:0] cnt     [N_CH];
  logic [CNT_W-1:0] per_val [N_CH];
  logic [N_CH-1:0]  periodic, active, pending, ovr;
  logic [CH_W-1:0]  last;
  logic             exp_valid;
  logic [CH_W-1:0]  exp_ch;

  logic [N_CH-1:0]  arm_hit, expire, cand, consume;
  logic             load_en, found;
  logic [CH_W-1:0]  sel;

  always_comb begin
    arm_hit = '0;
    expire  = '0;
    consume = '0;
    found   = 1'b0;
    sel     = '0;
    load_en = !exp_valid || bus.i_exp_ready;
    for (int i = 0; i < N_CH; i++) begin
      arm_hit[i] = bus.i_arm && (int'(bus.i_arm_ch) == i);
      expire[i]  = i_stb && active[i] && !arm_hit[i] && (cnt[i] == CNT_W'(1));
    end
    // An arm on this edge cancels the channel's pending event, so it must not be picked.
    cand = pending & ~arm_hit;
    for (int k = 1; k <= N_CH; k++) begin
      if (!found && cand[(int'(last) + k) % N_CH]) begin
        found = 1'b1;
        sel   = CH_W'((int'(last) + k) % N_CH);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      consume[i] = load_en && found && (int'(sel) == i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]     <= '0;
        per_val[i] <= '0;
      end
      periodic  <= '0;
      active    <= '0;
      pending   <= '0;
      ovr       <= '0;
      exp_valid <= 1'b0;
      exp_ch    <= '0;
      last      <= CH_W'(N_CH - 1);
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (arm_hit[i]) begin
          if (bus.i_arm_cnt != '0) begin
            cnt[i]      <= bus.i_arm_cnt;
            per_val[i]  <= bus.i_arm_cnt;
            periodic[i] <= bus.i_arm_per;
            active[i]   <= 1'b1;
          end else begin
            cnt[i]    <= '0;
            active[i] <= 1'b0;
          end
          pending[i] <= 1'b0;
          ovr[i]     <= 1'b0;
        end else begin
          if (i_stb && active[i]) begin
            if (cnt[i] > CNT_W'(1)) begin
              cnt[i] <= cnt[i] - CNT_W'(1);
            end else if (periodic[i]) begin
              cnt[i] <= per_val[i];
            end else begin
              cnt[i]    <= '0;
              active[i] <= 1'b0;
            end
          end
          // A fresh expiry outranks consumption of the previous one on the same edge.
          if (expire[i]) begin
            pending[i] <= 1'b1;
            if (pending[i] && !consume[i]) ovr[i] <= 1'b1;
          end else if (consume[i]) begin
            pending[i] <= 1'b0;
          end
        end
      end
      if (load_en) begin
        exp_valid <= found;
        if (found) begin
          exp_ch <= sel;
          last   <= sel;
        end
      end
    end
  end

  assign bus.o_exp_valid = exp_valid;
  assign bus.o_exp_ch    = exp_ch;
  assign o_active        = active;
  assign o_ovr           = ovr;

endmodule

// File: tb/tb_tick_sched.sv
// tb/tb_tick_sched.sv - scoreboard bench for tick_sched
module tb_tick_sched;
  localparam int N_CH  = 4;
  localparam int CH_W  = 2;
  localparam int CNT_W = 16;

  logic            clk;
  logic            rst_n;
  logic            stb;
  logic [N_CH-1:0] active;
  logic [N_CH-1:0] ovr;

  int n_vec = 0;
  int n_err = 0;
  int sb[$];

  tick_sched_if #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  tick_sched #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_stb    (stb),
    .bus      (bus),
    .o_active (active),
    .o_ovr    (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every accepted event is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (rst_n && bus.o_exp_valid && bus.i_exp_ready) begin
      if (sb.size() == 0) chk("spurious_event", bus.o_exp_valid, 1'b0);
      else                chk("event_ch", 32'(bus.o_exp_ch), 32'(sb.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stb = 1'b0;
    bus.i_arm = 1'b0;
    bus.i_exp_ready = 1'b0;
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic arm(input int ch, input int cnt, input bit per);
    bus.i_arm     = 1'b1;
    bus.i_arm_ch  = CH_W'(ch);
    bus.i_arm_cnt = CNT_W'(cnt);
    bus.i_arm_per = per;
    step();
    bus.i_arm = 1'b0;
  endtask

  task automatic strobe(input int gap);
    stb = 1'b1;
    step();
    stb = 1'b0;
    repeat (gap - 1) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    stb = 1'b0;
    bus.i_arm = 1'b0;
    bus.i_arm_ch = '0;
    bus.i_arm_cnt = '0;
    bus.i_arm_per = 1'b0;
    bus.i_exp_ready = 1'b0;

    // Post-reset state and one-shot expiry timing
    do_reset();
    chk("rst_valid", bus.o_exp_valid, 0);
    chk("rst_ch", 32'(bus.o_exp_ch), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_ovr", 32'(ovr), 0);
    bus.i_exp_ready = 1'b1;
    arm(0, 3, 1'b0);
    chk("os_active", active[0], 1);
    strobe(1024);
    strobe(1024);
    sb.push_back(0);
    stb = 1'b1;
    step();
    stb = 1'b0;
    @(negedge clk);
    chk("os_valid_e0", bus.o_exp_valid, 0);
    @(negedge clk);
    chk("os_valid_e1", bus.o_exp_valid, 1);
    chk("os_ch", 32'(bus.o_exp_ch), 0);
    @(negedge clk);
    chk("os_valid_e2", bus.o_exp_valid, 0);
    chk("os_inactive", active[0], 0);
    step();
    chk("os_sb_empty", sb.size(), 0);

    // Periodic mode
    do_reset();
    bus.i_exp_ready = 1'b1;
    arm(2, 2, 1'b1);
    for (int s = 1; s <= 6; s++) begin
      if (s % 2 == 0) sb.push_back(2);
      strobe(16);
    end
    chk("per_active", active[2], 1);
    chk("per_ovr", ovr[2], 0);
    chk("per_sb_empty", sb.size(), 0);
    arm(2, 0, 1'b0);
    chk("per_cancel", active[2], 0);

    // Overrun
    do_reset();
    arm(1, 1, 1'b1);
    sb.push_back(1);
    sb.push_back(1);
    strobe(8);
    chk("ov_loaded", bus.o_exp_valid, 1);
    chk("ov_ovr_s1", ovr[1], 0);
    strobe(8);
    chk("ov_ovr_s2", ovr[1], 0);
    strobe(8);
    chk("ov_ovr_s3", ovr[1], 1);
    bus.i_exp_ready = 1'b1;
    repeat (5) step();
    chk("ov_sb_empty", sb.size(), 0);
    chk("ov_drained", bus.o_exp_valid, 0);
    arm(1, 0, 1'b0);
    chk("ov_rearm_clr", ovr[1], 0);
    chk("ov_rearm_act", active[1], 0);

    // Round-robin fairness
    do_reset();
    for (int c = 0; c < N_CH; c++) begin
      arm(c, 1, 1'b0);
      sb.push_back(c);
    end
    strobe(3);
    chk("rr_held_valid", bus.o_exp_valid, 1);
    chk("rr_held_ch", 32'(bus.o_exp_ch), 0);
    bus.i_exp_ready = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      @(negedge clk);
      chk("rr_b2b_valid", bus.o_exp_valid, 1);
    end
    @(negedge clk);
    chk("rr_done_valid", bus.o_exp_valid, 0);
    step();
    chk("rr_sb_empty", sb.size(), 0);

    // Arm/strobe collision, then cancel
    do_reset();
    bus.i_exp_ready = 1'b1;
    stb = 1'b1;
    arm(3, 5, 1'b0);
    stb = 1'b0;
    chk("col_active", active[3], 1);
    for (int s = 1; s <= 5; s++) begin
      if (s == 5) sb.push_back(3);
      strobe(8);
    end
    chk("col_sb_empty", sb.size(), 0);
    chk("col_inactive", active[3], 0);
    arm(3, 5, 1'b0);
    strobe(8);
    strobe(8);
    arm(3, 0, 1'b0);
    chk("cxl_active", active[3], 0);
    repeat (5) strobe(8);
    chk("cxl_valid", bus.o_exp_valid, 0);

    // Asynchronous reset mid-operation
    do_reset();
    arm(0, 1, 1'b0);
    arm(1, 10, 1'b1);
    arm(2, 10, 1'b1);
    strobe(4);
    chk("mid_pre_valid", bus.o_exp_valid, 1);
    chk("mid_pre_active", 32'(active), 32'h6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", bus.o_exp_valid, 0);
    chk("mid_async_active", 32'(active), 0);
    step();
    rst_n = 1'b1;
    bus.i_exp_ready = 1'b1;
    repeat (12) strobe(4);
    chk("mid_post_active", 32'(active), 0);
    chk("mid_post_valid", bus.o_exp_valid, 0);
    chk("mid_post_ovr", 32'(ovr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tick_sched.md
# tick_sched

Multi-channel tick timer scheduler driven by the 46.875 kHz strobe of the system clock divider. It shares the single divided-clock strobe among `N_CH` independent countdown channels. Each channel is armed as a one-shot or periodic timer. Expiry events are reported one at a time through a valid/ready handshake with round-robin fairness. Sits between the clock divider and the cores that need slow timeouts or periodic service, such as LED blink, polling and watchdog.

## Interface
- `N_CH`, 4: number of timer channels (2..16).
- `CH_W`, 2: channel index width, equal to clog2(`N_CH`).
- `CNT_W`, 16: tick counter width.
- `i_clk`  in  1: system clock (48 MHz).
- `i_rst_n`  in  1: reset, asynchronous, active-low. One clock domain only.
- `i_stb`  in  1: tick strobe, high for one `i_clk` cycle per tick.
- `i_arm`  in  1: arm/cancel command, sampled each cycle and always accepted.
- `i_arm_ch`  in  `CH_W`: target channel. Values ≥ `N_CH` are ignored.
- `i_arm_cnt`  in  `CNT_W`: ticks until expiry. A value of 0 cancels the channel.
- `i_arm_per`  in  1: 1 = periodic (reload `i_arm_cnt` on expiry), 0 = one-shot.
- `o_exp_valid`  out  1: expiry event available.
- `o_exp_ch`  out  `CH_W`: channel of the presented event.
- `i_exp_ready`  in  1: consumer accepts the event.
- `o_active`  out  `N_CH`: channel is counting.
- `o_ovr`  out  `N_CH`: sticky overrun flag per channel.

## Operation
- Per-channel state: `cnt[CNT_W]`, `per_val[CNT_W]`, `periodic`, `active`, `pending`, `ovr`.
- Arm command (`i_arm` high, valid channel):
  - If `i_arm_cnt` ≠ 0: `cnt` and `per_val` ← `i_arm_cnt`, `periodic` ← `i_arm_per`, `active` ← 1.
  - If `i_arm_cnt` = 0: `active` ← 0.
  - In both cases `pending` ← 0 and `ovr` ← 0.
  - An event already loaded into the output register is not retracted.
- Tick (`i_stb` high): every active channel not being armed on the same edge does the following.
  - If `cnt` > 1: `cnt` ← `cnt` − 1.
  - If `cnt` = 1 (expiry) and the channel is one-shot: `active` ← 0 and `pending` ← 1.
  - If `cnt` = 1 (expiry) and the channel is periodic: `cnt` ← `per_val`, `active` stays 1, `pending` ← 1.
  - If `pending` was already 1 and is not being consumed on this edge, `ovr` ← 1. The event is merged, not queued.
- Arm and tick on the same edge and channel: the arm wins. The new count is loaded undecremented.
- Output register:
  - When the register is empty (`o_exp_valid` = 0), or a handshake completes this edge (`o_exp_valid` & `i_exp_ready`), it loads the next pending channel.
  - The search is round-robin, starting at `last`+1 and wrapping modulo `N_CH`.
  - The loaded channel's `pending` is cleared and `last` ← that channel.
  - If no channel is pending, `o_exp_valid` ← 0 after the handshake.
- If the same channel expires on the edge its `pending` is consumed, set dominates clear: `pending` stays 1 and `ovr` is not set.
- Counters never wrap. A counter of 0 occurs only in the inactive state.

## Timing
- Reset (async assert, sync-style deassert handled upstream) clears the following:
  - `o_exp_valid` = 0, `o_exp_ch` = 0, `o_active` = 0, `o_ovr` = 0.
  - All `cnt`/`per_val` = 0, `pending` = 0, `last` = `N_CH`−1, so the first search starts at channel 0.
- Arm takes effect on the edge it is sampled. `o_active` is visible the next cycle.
- A channel armed with count K expires on the K-th strobe after the arm edge. A strobe on the arm edge itself does not count.
- Expiry edge E sets `pending`. `o_exp_valid` rises at edge E+1 if the output register was empty, so the event is visible one cycle after the expiring strobe.
- `o_exp_valid`/`o_exp_ch` are held stable until the handshake. Back-to-back events are possible: one per cycle while `i_exp_ready` = 1.
- Reset mid-operation discards all counts and events immediately.

## Test plan
- Post-reset state:
  - Release reset; all outputs are 0.
  - Arm ch0 with cnt=3, one-shot.
  - Apply strobes every 1024 cycles with `i_exp_ready`=1.
  - Required: `o_exp_valid` high for exactly 1 cycle, `o_exp_ch`=0, one cycle after the 3rd strobe; `o_active[0]`=0 afterwards.
- Periodic mode:
  - Arm ch2 with cnt=2, periodic, `i_exp_ready`=1.
  - Required: events on strobes 2, 4, 6 and onward; `o_active[2]` stays 1; `o_ovr[2]`=0.
- Overrun:
  - Arm ch1 with cnt=1, periodic; hold `i_exp_ready`=0.
  - Required: the first event is loaded at strobe 1. Strobe 2 sets `pending`. Strobe 3 sets `o_ovr[1]`=1.
  - Then raise `i_exp_ready`: exactly 2 events are delivered (ch1, ch1).
  - Re-arming ch1 clears `o_ovr[1]`.
- Round-robin fairness:
  - Arm ch0–ch3 each with cnt=1, all one-shot.
  - Hold `i_exp_ready`=0 through the strobe, then raise it.
  - Required: the event order is 0, 1, 2, 3, delivered back-to-back on consecutive cycles.
- Arm/strobe collision and cancel:
  - Arm ch3 with cnt=5 on the same edge as a strobe. Required: expiry occurs on the 5th subsequent strobe.
  - Separately, arm cnt=0 after 2 strobes. Required: `o_active[3]`=0 and no event is produced.
- Reset mid-operation:
  - Assert `i_rst_n`=0 asynchronously between clock edges while `o_exp_valid`=1 and 2 channels are active.
  - Required: `o_exp_valid` drops without waiting for a clock edge, and no events appear after reset release.
